// File: rtl/node_update_ctrl.sv
`default_nettype none
// ============================================================================
// node_update_ctrl : write / read-back / verify / retry controller that shares
//                    node memory port B with a higher-priority lookup client.
// Revision 1.0
// ============================================================================
module node_update_ctrl #(
   parameter int NODE_WIDTH = 40,
   parameter int ADDR_WIDTH = 6,
   parameter int MAX_RETRY  = 3
) (
   input  logic                  clk,
   input  logic                  RST,
   // update stream
   input  logic                  upd_valid,
   output logic                  upd_ready,
   input  logic [ADDR_WIDTH-1:0] upd_addr,
   input  logic [NODE_WIDTH-1:0] upd_node,
   input  logic                  upd_last,
   // lookup side
   input  logic                  lkp_valid2,
   input  logic [ADDR_WIDTH-1:0] lkp_addr2,
   // memory port B
   output logic                  bram_web,
   output logic [ADDR_WIDTH-1:0] bram_addrb,
   output logic [NODE_WIDTH-1:0] bram_dinb,
   input  logic [NODE_WIDTH-1:0] bram_doutb,
   // status
   output logic                  upd_busy,
   output logic                  upd_done,
   output logic                  upd_err,
   output logic [ADDR_WIDTH-1:0] err_addr,
   output logic [ADDR_WIDTH:0]   upd_count
);

   localparam int RETRY_W = (MAX_RETRY > 2) ? $clog2(MAX_RETRY) : 1;
   localparam logic [RETRY_W-1:0]  RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
   localparam logic [ADDR_WIDTH:0] COUNT_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_WAIT  = 3'd3,
      S_CHECK = 3'd4
   } state_t;

   state_t                  state_q,    state_d;
   logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
   logic [NODE_WIDTH-1:0]   node_q,     node_d;
   logic                    last_q,     last_d;
   logic [RETRY_W-1:0]      retry_q,    retry_d;
   logic [ADDR_WIDTH:0]     count_q,    count_d;
   logic                    clr_q,      clr_d;
   logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
   logic                    ready_q,    ready_d;
   logic                    match;

   assign match = (bram_doutb == node_q);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      node_d     = node_q;
      last_d     = last_q;
      retry_d    = retry_q;
      count_d    = count_q;
      clr_d      = 1'b0;
      err_addr_d = err_addr_q;
      upd_done   = 1'b0;
      upd_err    = 1'b0;

      // A verified final entry leaves its count visible for one cycle, then clears.
      if (clr_q) begin
         count_d = '0;
      end

      case (state_q)
         S_IDLE: begin
            if (upd_valid && ready_q) begin
               addr_d  = upd_addr;
               node_d  = upd_node;
               last_d  = upd_last;
               retry_d = '0;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (!lkp_valid2) begin
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (!lkp_valid2) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (match) begin
               if (count_q != COUNT_MAX) begin
                  count_d = count_q + 1'b1;
               end
               upd_done = last_q;
               clr_d    = last_q;
               state_d  = S_IDLE;
            end else if (retry_q < RETRY_LAST) begin
               retry_d = retry_q + 1'b1;
               state_d = S_WRITE;
            end else begin
               upd_err    = 1'b1;
               upd_done   = last_q;
               err_addr_d = addr_q;
               state_d    = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ready_d = (state_d == S_IDLE);

      if (RST) begin
         upd_done = 1'b0;
         upd_err  = 1'b0;
      end
   end

   // Port B: lookup always wins; the updater only drives it in WRITE/READ.
   always_comb begin
      bram_web   = 1'b0;
      bram_addrb = '0;
      bram_dinb  = '0;
      if (!RST) begin
         if (lkp_valid2) begin
            bram_addrb = lkp_addr2;
         end else if (state_q == S_WRITE) begin
            bram_web   = 1'b1;
            bram_addrb = addr_q;
            bram_dinb  = node_q;
         end else if (state_q == S_READ) begin
            bram_addrb = addr_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         node_q     <= '0;
         last_q     <= 1'b0;
         retry_q    <= '0;
         count_q    <= '0;
         clr_q      <= 1'b0;
         err_addr_q <= '0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         node_q     <= node_d;
         last_q     <= last_d;
         retry_q    <= retry_d;
         count_q    <= count_d;
         clr_q      <= clr_d;
         err_addr_q <= err_addr_d;
         ready_q    <= ready_d;
      end
   end

   assign upd_ready = ready_q;
   assign upd_busy  = (state_q != S_IDLE);
   assign err_addr  = err_addr_q;
   assign upd_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_node_update_ctrl.sv
`default_nettype none
// ============================================================================
// tb_node_update_ctrl : randomized self-checking bench with a latency memory
//                       model that can corrupt selected read-backs.
// Revision 1.0
// ============================================================================
module tb_node_update_ctrl;

   localparam int NW = 40;
   localparam int AW = 6;
   localparam int MR = 3;
   localparam int CMAX = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          upd_valid = 1'b0;
   logic          upd_ready;
   logic [AW-1:0] upd_addr = '0;
   logic [NW-1:0] upd_node = '0;
   logic          upd_last = 1'b0;
   logic          lkp_valid2 = 1'b0;
   logic [AW-1:0] lkp_addr2 = '0;
   logic          bram_web;
   logic [AW-1:0] bram_addrb;
   logic [NW-1:0] bram_dinb;
   logic [NW-1:0] bram_doutb;
   logic          upd_busy;
   logic          upd_done;
   logic          upd_err;
   logic [AW-1:0] err_addr;
   logic [AW:0]   upd_count;

   node_update_ctrl #(.NODE_WIDTH(NW), .ADDR_WIDTH(AW), .MAX_RETRY(MR)) dut (
      .clk(clk), .RST(rst),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr),
      .upd_node(upd_node), .upd_last(upd_last),
      .lkp_valid2(lkp_valid2), .lkp_addr2(lkp_addr2),
      .bram_web(bram_web), .bram_addrb(bram_addrb), .bram_dinb(bram_dinb),
      .bram_doutb(bram_doutb),
      .upd_busy(upd_busy), .upd_done(upd_done), .upd_err(upd_err),
      .err_addr(err_addr), .upd_count(upd_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory: 2-cycle read latency; the first non-lookup read of an address
   // after it is written may be corrupted while the corruption budget lasts.
   logic [NW-1:0] mem [0:CMAX-1];
   logic [NW-1:0] p1, p2;
   logic          armed = 1'b0;
   logic [AW-1:0] arm_addr = '0;
   int            bad_cnt = 0;
   int            bad_limit = 0;
   assign bram_doutb = p2;

   always @(posedge clk) begin
      p2 <= p1;
      if (bram_web) begin
         mem[bram_addrb] <= bram_dinb;
         armed    <= 1'b1;
         arm_addr <= bram_addrb;
         p1       <= mem[bram_addrb];
      end else if (armed && !lkp_valid2 && bram_addrb == arm_addr) begin
         armed <= 1'b0;
         if (bad_cnt < bad_limit) begin
            p1      <= mem[bram_addrb] ^ NW'(1);
            bad_cnt <= bad_cnt + 1;
         end else begin
            p1 <= mem[bram_addrb];
         end
      end else begin
         p1 <= mem[bram_addrb];
      end
   end

   // Event recorder
   logic [AW-1:0] exp_addr = '0;
   logic [NW-1:0] exp_node = '0;
   int wr_total = 0, wr_bad = 0, done_cnt = 0, err_cnt = 0;
   int done_cyc = 0, err_cyc = 0, rdy_viol = 0;

   always @(negedge clk) begin
      if (bram_web) begin
         wr_total <= wr_total + 1;
         if (bram_addrb !== exp_addr || bram_dinb !== exp_node) wr_bad <= wr_bad + 1;
      end
      if (upd_done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
      if (upd_err)  begin err_cnt  <= err_cnt + 1;  err_cyc  <= cyc; end
      if (upd_busy && upd_ready) rdy_viol <= rdy_viol + 1;
   end

   // Reference state
   int            model_count = 0;
   logic [AW-1:0] model_err_addr = '0;

   task automatic reset_dut();
      @(posedge clk); #1;
      rst = 1'b1; upd_valid = 1'b0; lkp_valid2 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_count = 0;
      model_err_addr = '0;
      bad_limit = bad_cnt;
   endtask

   // One entry: k corrupted read-backs, stall lookup cycles at WRITE, rnd lookups.
   task automatic do_entry(input logic [AW-1:0] a, input logic [NW-1:0] n, input logic l,
                           input int k, input int stall, input bit rnd);
      int att, acc, wr0, wb0, d0, e0;
      bit ok, got;
      att = (k + 1 < MR) ? k + 1 : MR;
      ok  = (k < MR);
      exp_addr = a; exp_node = n;
      bad_limit = bad_cnt + k;
      lkp_valid2 = 1'b0;
      got = 1'b0;
      for (int t = 0; t < 200; t++) begin
         if (upd_ready === 1'b1) begin got = 1'b1; break; end
         @(posedge clk); #1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL ready_wait addr=%0d: upd_ready=%b, required 1 within 200 cycles", a, upd_ready);
         return;
      end
      wr0 = wr_total; wb0 = wr_bad; d0 = done_cnt; e0 = err_cnt;
      upd_valid = 1'b1; upd_addr = a; upd_node = n; upd_last = l;
      acc = cyc;
      @(posedge clk); #1;
      upd_valid = 1'b0; upd_addr = AW'($urandom); upd_node = NW'({$urandom, $urandom});
      upd_last = 1'($urandom_range(0, 1));
      got = 1'b0;
      for (int j = 1; j < 400; j++) begin
         if (j <= stall) begin
            lkp_valid2 = 1'b1; lkp_addr2 = AW'($urandom);
         end else if (rnd) begin
            lkp_valid2 = ($urandom_range(0, 9) < 3); lkp_addr2 = AW'($urandom);
         end else begin
            lkp_valid2 = 1'b0;
         end
         @(negedge clk); #1;
         if (upd_busy === 1'b0) begin got = 1'b1; break; end
         if (lkp_valid2) begin
            checks++;
            if (bram_web !== 1'b0 || bram_addrb !== lkp_addr2) begin
               errors++;
               $display("FAIL lkp_priority cyc=%0d: web=%b addrb=%0d, required web=0 addrb=%0d",
                        cyc, bram_web, bram_addrb, lkp_addr2);
            end
         end
         if (!rnd && j == stall + 2) begin
            checks++;
            if (bram_web !== 1'b0 || bram_addrb !== a) begin
               errors++;
               $display("FAIL read_issue addr=%0d: web=%b addrb=%0d, required web=0 addrb=%0d",
                        a, bram_web, bram_addrb, a);
            end
         end
         @(posedge clk); #1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL busy_timeout addr=%0d: upd_busy=%b, required 0 within 400 cycles", a, upd_busy);
         return;
      end
      if (ok) model_count = (model_count + 1 > CMAX) ? CMAX : model_count + 1;
      else    model_err_addr = a;
      checks++;
      if (wr_total - wr0 != att) begin
         errors++;
         $display("FAIL write_count addr=%0d: got %0d writes, required %0d", a, wr_total - wr0, att);
      end
      checks++;
      if (wr_bad != wb0) begin
         errors++;
         $display("FAIL write_content addr=%0d: got %0d bad writes, required 0", a, wr_bad - wb0);
      end
      if (!rnd) begin
         checks++;
         if (cyc - 1 != acc + 4 * att + stall) begin
            errors++;
            $display("FAIL latency addr=%0d: check cycle at +%0d, required +%0d",
                     a, cyc - 1 - acc, 4 * att + stall);
         end
      end
      checks++;
      if (done_cnt - d0 != int'(l)) begin
         errors++;
         $display("FAIL done_pulse addr=%0d: got %0d pulses, required %0d", a, done_cnt - d0, int'(l));
      end
      checks++;
      if (err_cnt - e0 != (ok ? 0 : 1)) begin
         errors++;
         $display("FAIL err_pulse addr=%0d: got %0d pulses, required %0d", a, err_cnt - e0, ok ? 0 : 1);
      end
      if (l && !ok) begin
         checks++;
         if (done_cyc != err_cyc) begin
            errors++;
            $display("FAIL done_err_align addr=%0d: done cyc %0d, required err cyc %0d", a, done_cyc, err_cyc);
         end
      end
      checks++;
      if (upd_count !== (AW+1)'(model_count)) begin
         errors++;
         $display("FAIL upd_count addr=%0d: got %0d, required %0d", a, upd_count, model_count);
      end
      checks++;
      if (err_addr !== model_err_addr) begin
         errors++;
         $display("FAIL err_addr: got %0d, required %0d", err_addr, model_err_addr);
      end
      checks++;
      if (upd_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_return addr=%0d: got %b, required 1", a, upd_ready);
      end
      if (!lkp_valid2) begin
         checks++;
         if (bram_web !== 1'b0 || bram_addrb !== '0 || bram_dinb !== '0) begin
            errors++;
            $display("FAIL idle_port web=%b addrb=%0d dinb=%h, required all 0", bram_web, bram_addrb, bram_dinb);
         end
      end
      if (l && ok) begin
         model_count = 0;
         @(posedge clk); #1 lkp_valid2 = 1'b0;
         @(negedge clk); #1;
         checks++;
         if (upd_count !== '0) begin
            errors++;
            $display("FAIL count_clear addr=%0d: got %0d, required 0", a, upd_count);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if ({upd_ready, upd_busy, upd_done, upd_err, err_addr, upd_count, bram_web, bram_addrb, bram_dinb} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b busy=%b done=%b err=%b err_addr=%0d count=%0d web=%b addrb=%0d dinb=%h, required all 0",
                  upd_ready, upd_busy, upd_done, upd_err, err_addr, upd_count, bram_web, bram_addrb, bram_dinb);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (upd_ready !== 1'b0) begin
         errors++; $display("FAIL ready_release_same_cycle: got %b, required 0", upd_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (upd_ready !== 1'b1) begin
         errors++; $display("FAIL ready_after_release: got %b, required 1", upd_ready);
      end
   endtask

   task automatic test_single();
      reset_dut();
      do_entry(6'd5, 40'h12_3456_789A, 1'b1, 0, 0, 1'b0);
   endtask

   task automatic test_stall();
      do_entry(6'd5, 40'h12_3456_789A, 1'b1, 0, 3, 1'b0);
   endtask

   task automatic test_retry_once();
      do_entry(6'd9, NW'({$urandom, $urandom}), 1'b0, 1, 0, 1'b0);
   endtask

   task automatic test_fail_63();
      do_entry(6'd63, NW'({$urandom, $urandom}), 1'b1, 100, 0, 1'b0);
   endtask

   task automatic test_rst_wait();
      int d0, e0, w0;
      exp_addr = 6'd12; exp_node = NW'({$urandom, $urandom});
      bad_limit = bad_cnt;
      for (int t = 0; t < 50 && upd_ready !== 1'b1; t++) begin @(posedge clk); #1; end
      d0 = done_cnt; e0 = err_cnt; w0 = wr_total;
      upd_valid = 1'b1; upd_addr = exp_addr; upd_node = exp_node; upd_last = 1'b1;
      @(posedge clk); #1 upd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); #1;
      checks++;
      if ({upd_ready, upd_busy, upd_done, upd_err, err_addr, upd_count, bram_web, bram_addrb, bram_dinb} !== '0) begin
         errors++;
         $display("FAIL rst_wait_outputs: ready=%b busy=%b done=%b err=%b err_addr=%0d count=%0d web=%b addrb=%0d, required all 0",
                  upd_ready, upd_busy, upd_done, upd_err, err_addr, upd_count, bram_web, bram_addrb);
      end
      @(posedge clk); #1 rst = 1'b0;
      model_count = 0; model_err_addr = '0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (done_cnt != d0 || err_cnt != e0 || wr_total - w0 != 1) begin
         errors++;
         $display("FAIL rst_wait_abandon: done=%0d err=%0d writes=%0d, required 0 0 1",
                  done_cnt - d0, err_cnt - e0, wr_total - w0);
      end
      do_entry(6'd12, NW'({$urandom, $urandom}), 1'b1, 0, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      int v0;
      reset_dut();
      v0 = rdy_viol;
      for (int i = 0; i < CMAX; i++)
         do_entry(AW'(i), NW'({$urandom, $urandom}), (i == CMAX - 1), 0, 0, 1'b0);
      checks++;
      if (rdy_viol != v0) begin
         errors++; $display("FAIL ready_while_busy: got %0d cycles, required 0", rdy_viol - v0);
      end
   endtask

   task automatic test_saturate();
      reset_dut();
      for (int i = 0; i < CMAX + 2; i++)
         do_entry(AW'($urandom), NW'({$urandom, $urandom}), 1'b0, 0, 0, 1'b0);
   endtask

   task automatic test_random();
      reset_dut();
      for (int i = 0; i < 40; i++)
         do_entry(AW'($urandom), NW'({$urandom, $urandom}), ($urandom_range(0, 4) == 0),
                  $urandom_range(0, MR), $urandom_range(0, 2), 1'b1);
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_retry_once();
      test_fail_63();
      test_rst_wait();
      test_back_to_back();
      test_saturate();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/node_update_ctrl.md
NODE_UPDATE_CTRL -- requirements
Module: node_update_ctrl

Interface
REQ-001 SHALL have parameter NODE_WIDTH, default 40, the node entry width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, the node memory address width (64 entries).
REQ-003 SHALL have parameter MAX_RETRY, default 3, the write attempts allowed per entry.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; RST  in  1  synchronous active-high reset.
REQ-005 SHALL have the update-stream handshake: upd_valid  in  1  entry offered; upd_ready  out  1  entry accepted when both are high; upd_addr  in  ADDR_WIDTH  target entry; upd_node  in  NODE_WIDTH  entry data; upd_last  in  1  final entry of the batch.
REQ-006 SHALL have the lookup-side port: lkp_valid2  in  1  lookup owns memory port B this cycle; lkp_addr2  in  ADDR_WIDTH  lookup address.
REQ-007 SHALL have the memory port-B drive: bram_web  out  1  write enable; bram_addrb  out  ADDR_WIDTH  address; bram_dinb  out  NODE_WIDTH  write data; bram_doutb  in  NODE_WIDTH  read data, valid 2 cycles after the address.
REQ-008 SHALL have the status outputs: upd_busy  out  1  an entry is in flight; upd_done  out  1  one-cycle batch-complete pulse; upd_err  out  1  one-cycle entry-failed pulse; err_addr  out  ADDR_WIDTH  address of the last failed entry; upd_count  out  ADDR_WIDTH+1  entries verified in the current batch.

Function
REQ-009 SHALL implement the FSM states IDLE, WRITE, READ, WAIT, CHECK.
REQ-010 SHALL hold upd_ready=1 only in IDLE; on upd_valid&upd_ready it SHALL latch addr, node and last, clear the retry counter, and go to WRITE.
REQ-011 SHALL give lookup absolute priority: when lkp_valid2=1, bram_addrb=lkp_addr2 and bram_web=0 in every state.
REQ-012 In WRITE with lkp_valid2=0, SHALL drive bram_web=1, bram_addrb=latched addr, bram_dinb=latched node for exactly one cycle, then go to READ; with lkp_valid2=1 it SHALL stay in WRITE.
REQ-013 In READ with lkp_valid2=0, SHALL drive bram_addrb=latched addr, bram_web=0, then go to WAIT; with lkp_valid2=1 it SHALL stay in READ.
REQ-014 WAIT SHALL last one cycle unconditionally; CHECK SHALL sample bram_doutb exactly 2 cycles after the READ issue cycle, whatever lkp_valid2 does meanwhile.
REQ-015 In CHECK on a match, SHALL increment upd_count; if last=1 it SHALL pulse upd_done and clear upd_count on the following cycle; it SHALL return to IDLE.
REQ-016 In CHECK on a mismatch with retries < MAX_RETRY-1, SHALL increment the retry counter and go to WRITE.
REQ-017 In CHECK on a mismatch when MAX_RETRY attempts are exhausted, SHALL pulse upd_err, load err_addr, leave upd_count unchanged, and return to IDLE.
REQ-018 If last=1 on an entry that fails (REQ-017), SHALL also pulse upd_done in the same cycle as upd_err.
REQ-019 SHALL drive upd_busy=1 in every state except IDLE.
REQ-020 When idle and lkp_valid2=0, SHALL drive bram_addrb=0, bram_web=0 and bram_dinb=0.
REQ-021 upd_count SHALL saturate at 2^ADDR_WIDTH.

Reset
REQ-022 While RST=1 at a clk edge, SHALL force state IDLE, upd_ready=0, upd_busy=0, upd_done=0, upd_err=0, err_addr=0, upd_count=0, bram_web=0, bram_addrb=0, bram_dinb=0, retry=0; upd_ready SHALL rise the first cycle after RST falls.
REQ-023 RST asserted mid-entry SHALL abandon the entry without a further write, done or err pulse.

Verification
REQ-024 Single entry addr=5, node=40'h12_3456_789A, last=1, lkp_valid2=0, memory model correct -> one web pulse at addr 5, read at addr 5, upd_done 4 cycles after acceptance, upd_count=1, then 0.
REQ-025 Same entry with lkp_valid2=1 for 3 cycles starting at WRITE -> web delayed 3 cycles, bram_addrb=lkp_addr2 during the stall, no write lost.
REQ-026 Memory model corrupts the first readback of addr 9 -> exactly two web pulses at addr 9, no upd_err, upd_count increments once.
REQ-027 Memory model always corrupts addr 63, last=1 -> three write attempts, upd_err and upd_done in the same cycle, err_addr=63, upd_count unchanged.
REQ-028 Batch of 64 back-to-back entries addr 0..63 -> upd_count reaches 64, upd_done on entry 63, upd_ready low from each acceptance until CHECK completes.
REQ-029 RST pulsed during WAIT -> no done or err pulse, all outputs at reset values, next entry accepted normally.
